// File: rtl/rd_bank_arbiter.sv
// rd_bank_arbiter: per-bank round-robin read arbiter in front of the read switch.
// At most one agent is granted per bank per cycle. Grants drive the switch enables,
// addresses and selects combinationally. rsp_valid/rsp_err mark the cycle the bank
// data returns, and a saturating counter tracks cycles with ungranted in-range requests.
module rd_bank_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NB_WRAGENT   = 2,
    parameter int unsigned NB_RDAGENT   = 2,
    parameter int unsigned SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int unsigned COLL_WIDTH   = 16
) (
    input  logic                               aclk,
    input  logic                               srst,
    input  logic [NB_RDAGENT-1:0]              req_valid,
    output logic [NB_RDAGENT-1:0]              req_ready,
    input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] req_bank,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   req_addr,
    output logic [NB_RDAGENT-1:0]              m_rden,
    output logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
    output logic [NB_RDAGENT-1:0]              rsp_valid,
    output logic [NB_RDAGENT-1:0]              rsp_err,
    input  logic                               clr_stat,
    output logic [COLL_WIDTH-1:0]              coll_cnt
);

    localparam int unsigned AGENT_W = (NB_RDAGENT == 1) ? 1 : $clog2(NB_RDAGENT);

    logic [AGENT_W-1:0]    ptr_q [NB_WRAGENT];
    logic [AGENT_W-1:0]    ptr_d [NB_WRAGENT];
    logic [NB_RDAGENT-1:0] grant;
    logic [NB_RDAGENT-1:0] oor;
    logic                  coll_evt;
    logic [NB_RDAGENT-1:0] rsp_valid_d;
    logic [NB_RDAGENT-1:0] rsp_err_d;
    logic [COLL_WIDTH-1:0] coll_cnt_d;

    // Flag requests aimed at banks that do not exist (widened compare stays non-constant)
    always_comb begin
        oor = '0;
        for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
            oor[i] = req_valid[i] &&
                     ({1'b0, req_bank[i*SELECT_WIDTH +: SELECT_WIDTH]} >= (SELECT_WIDTH+1)'(NB_WRAGENT));
        end
    end

    // Per-bank round-robin search starting at the bank pointer; pointer moves past the winner
    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        grant = '0;
        for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
            ptr_d[b] = ptr_q[b];
            found    = 1'b0;
            for (int unsigned k = 0; k < NB_RDAGENT; k++) begin
                idx = (32'(ptr_q[b]) + k) % NB_RDAGENT;
                if (!found && req_valid[idx] &&
                    (req_bank[idx*SELECT_WIDTH +: SELECT_WIDTH] == SELECT_WIDTH'(b))) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d[b]   = AGENT_W'((idx + 1) % NB_RDAGENT);
                end
            end
        end
    end

    // Switch-facing outputs and handshake; all forced low while in reset
    always_comb begin
        req_ready = '0;
        m_rden    = '0;
        m_rdaddr  = '0;
        rdselect  = '0;
        if (!srst) begin
            req_ready = grant | oor;
            m_rden    = grant;
            for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
                if (grant[i]) begin
                    m_rdaddr[i*ADDR_WIDTH +: ADDR_WIDTH]     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    rdselect[i*SELECT_WIDTH +: SELECT_WIDTH] = req_bank[i*SELECT_WIDTH +: SELECT_WIDTH];
                end
            end
        end
    end

    // Next-state for response flags and the saturating collision counter
    always_comb begin
        rsp_valid_d = req_valid & req_ready;
        rsp_err_d   = oor & req_ready;
        coll_evt    = |(req_valid & ~oor & ~grant);
        coll_cnt_d  = coll_cnt;
        if (clr_stat) begin
            coll_cnt_d = '0;
        end else if (coll_evt && (coll_cnt != {COLL_WIDTH{1'b1}})) begin
            coll_cnt_d = coll_cnt + COLL_WIDTH'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
                ptr_q[b] <= '0;
            end
            rsp_valid <= '0;
            rsp_err   <= '0;
            coll_cnt  <= '0;
        end else begin
            for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            coll_cnt  <= coll_cnt_d;
        end
    end

endmodule

// File: tb/tb_rd_bank_arbiter.sv
// Directed bench for rd_bank_arbiter: default instance (2 banks, 2 agents) and a
// 3-bank instance with a 2-bit collision counter for out-of-range and saturation cases.
module tb_rd_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // instance A: defaults
    logic        a_srst, a_clr;
    logic [1:0]  a_valid, a_ready, a_rden, a_rsp_valid, a_rsp_err, a_bank, a_rdselect;
    logic [15:0] a_addr, a_rdaddr, a_coll;

    // instance B: 3 banks, 2-bit counter
    logic        b_srst, b_clr;
    logic [1:0]  b_valid, b_ready, b_rden, b_rsp_valid, b_rsp_err, b_coll;
    logic [3:0]  b_bank, b_rdselect;
    logic [15:0] b_addr, b_rdaddr;

    rd_bank_arbiter dut_a (
        .aclk(clk), .srst(a_srst), .req_valid(a_valid), .req_ready(a_ready),
        .req_bank(a_bank), .req_addr(a_addr), .m_rden(a_rden), .m_rdaddr(a_rdaddr),
        .rdselect(a_rdselect), .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err),
        .clr_stat(a_clr), .coll_cnt(a_coll)
    );

    rd_bank_arbiter #(.NB_WRAGENT(3), .COLL_WIDTH(2)) dut_b (
        .aclk(clk), .srst(b_srst), .req_valid(b_valid), .req_ready(b_ready),
        .req_bank(b_bank), .req_addr(b_addr), .m_rden(b_rden), .m_rdaddr(b_rdaddr),
        .rdselect(b_rdselect), .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err),
        .clr_stat(b_clr), .coll_cnt(b_coll)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        a_srst = 1'b1; a_clr = 1'b0; a_valid = 2'b11; a_bank = 2'b00; a_addr = 16'hFFFF;
        b_srst = 1'b1; b_clr = 1'b0; b_valid = 2'b11; b_bank = 4'b0000; b_addr = 16'hFFFF;

        // reset held with requests pending
        tick(); tick(); tick();
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_rden", 32'(a_rden), 32'h0);
        chk("rst_rdaddr", 32'(a_rdaddr), 32'h0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("rst_coll", 32'(a_coll), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);

        // single agent0 -> bank1, addr 0x12
        a_srst = 1'b0; a_valid = 2'b01; a_bank = 2'b01; a_addr = 16'h0012;
        #1;
        chk("single_ready", 32'(a_ready), 32'h1);
        chk("single_rden", 32'(a_rden), 32'h1);
        chk("single_rdaddr", 32'(a_rdaddr), 32'h0012);
        chk("single_rdselect", 32'(a_rdselect), 32'h1);
        tick();
        chk("single_rsp_valid", 32'(a_rsp_valid), 32'h1);
        chk("single_rsp_err", 32'(a_rsp_err), 32'h0);
        chk("single_coll", 32'(a_coll), 32'h0);

        // both agents on bank0 for 4 cycles: grants 0,1,0,1
        a_valid = 2'b11; a_bank = 2'b00; a_addr = 16'hB1A0;
        #1;
        chk("rr0_ready", 32'(a_ready), 32'h1);
        chk("rr0_rdaddr", 32'(a_rdaddr), 32'h00A0);
        chk("rr0_rdselect", 32'(a_rdselect), 32'h0);
        tick();
        chk("rr1_rsp_valid", 32'(a_rsp_valid), 32'h1);
        chk("rr1_coll", 32'(a_coll), 32'h1);
        chk("rr1_ready", 32'(a_ready), 32'h2);
        chk("rr1_rdaddr", 32'(a_rdaddr), 32'hB100);
        tick();
        chk("rr2_rsp_valid", 32'(a_rsp_valid), 32'h2);
        chk("rr2_ready", 32'(a_ready), 32'h1);
        tick();
        chk("rr3_rsp_valid", 32'(a_rsp_valid), 32'h1);
        chk("rr3_ready", 32'(a_ready), 32'h2);
        tick();
        chk("rr4_rsp_valid", 32'(a_rsp_valid), 32'h2);
        chk("rr4_coll", 32'(a_coll), 32'h4);

        // different banks in the same cycle: both granted, no collision
        a_bank = 2'b10; a_addr = 16'h3412;
        #1;
        chk("par_ready", 32'(a_ready), 32'h3);
        chk("par_rden", 32'(a_rden), 32'h3);
        chk("par_rdselect", 32'(a_rdselect), 32'h2);
        chk("par_rdaddr", 32'(a_rdaddr), 32'h3412);
        tick();
        chk("par_rsp_valid", 32'(a_rsp_valid), 32'h3);
        chk("par_coll", 32'(a_coll), 32'h4);
        a_valid = 2'b00; a_clr = 1'b1;
        tick();
        chk("a_clr_coll", 32'(a_coll), 32'h0);
        chk("a_idle_rsp_valid", 32'(a_rsp_valid), 32'h0);
        a_clr = 1'b0;

        // out-of-range bank 3 on a 3-bank instance
        b_srst = 1'b0; b_valid = 2'b10; b_bank = 4'b1100; b_addr = 16'h5500;
        #1;
        chk("oor_ready", 32'(b_ready), 32'h2);
        chk("oor_rden", 32'(b_rden), 32'h0);
        chk("oor_rdaddr", 32'(b_rdaddr), 32'h0);
        chk("oor_rdselect", 32'(b_rdselect), 32'h0);
        tick();
        chk("oor_rsp_valid", 32'(b_rsp_valid), 32'h2);
        chk("oor_rsp_err", 32'(b_rsp_err), 32'h2);
        chk("oor_coll", 32'(b_coll), 32'h0);

        // five collision cycles saturate the 2-bit counter
        b_valid = 2'b11; b_bank = 4'b0000; b_addr = 16'h2211;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("sat_ready", 32'(b_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
            tick();
            chk("sat_coll", 32'(b_coll), (k < 3) ? 32'(k + 1) : 32'h3);
            chk("sat_rsp_valid", 32'(b_rsp_valid), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("sat_rsp_err", 32'(b_rsp_err), 32'h0);
        end

        // clear wins over a collision in the same cycle
        b_clr = 1'b1;
        #1;
        chk("clr_ready", 32'(b_ready), 32'h2);
        tick();
        chk("clr_coll", 32'(b_coll), 32'h0);
        b_clr = 1'b0;
        #1;
        chk("post_clr_ready", 32'(b_ready), 32'h1);
        tick();
        chk("post_clr_coll", 32'(b_coll), 32'h1);
        chk("post_clr_rsp_valid", 32'(b_rsp_valid), 32'h1);

        // reset right after a grant: flags drop, pointer returns to agent0
        b_srst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(b_ready), 32'h0);
        tick();
        chk("mid_rst_rsp_valid", 32'(b_rsp_valid), 32'h0);
        chk("mid_rst_coll", 32'(b_coll), 32'h0);
        b_srst = 1'b0;
        #1;
        chk("mid_rst_ptr_ready", 32'(b_ready), 32'h1);
        tick();
        chk("mid_rst_ptr_rsp_valid", 32'(b_rsp_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
